writeback_stage: RTL and testbench
==================================

# writeback_stage

MEM/WB pipeline register and writeback driver for the 32-bit MIPS core: the write-side counterpart of the ID-stage register file. It latches the retiring instruction from MEM, forms the final result (ALU result, link address, or aligned and extended load data), and drives the register-file write port. It also provides the write-through bypass so that ID reads in the writeback cycle see the new value, and it counts retired instructions.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register address.
- clk  in  1  rising-edge clock shared with the register file.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_stall  in  1  hold the WB register; suppresses the write and retire for this cycle.
- wb_flush  in  1  invalidate the instruction captured at the next edge.
- mem_valid  in  1  MEM holds a real instruction.
- mem_reg_write  in  1  instruction writes a GPR.
- mem_mem_to_reg  in  1  result comes from load data.
- mem_link  in  1  result is mem_link_addr (JAL/JALR).
- mem_load_size  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- mem_load_unsigned  in  1  zero-extend (LBU/LHU), else sign-extend.
- mem_byte_off  in  2  low address bits of the load.
- mem_dest  in  5  destination register.
- mem_alu_result  in  32  ALU result.
- mem_load_data  in  32  raw data-memory word.
- mem_link_addr  in  32  PC+8.
- rd_addr1, rd_addr2  in  5 each  ID read addresses.
- rf_rdata1, rf_rdata2  in  32 each  raw register-file read data.
- rf_write  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_data  out  32  register-file write data.
- byp_data1, byp_data2  out  32 each  bypassed operands to ID.
- retire_count  out  32  count of retired valid instructions.

## Operation
- Stage register: on each rising edge with wb_stall=0, capture all mem_* fields. The valid bit captured is mem_valid & ~wb_flush.
- With wb_stall=1, hold the register contents. Exception: wb_flush=1 clears valid even while stalled. Flush has priority over stall.
- Load extraction (big-endian):
  - Byte: offset 0 selects bits 31:24 and offset 3 selects bits 7:0.
  - Halfword: off[1]=0 selects bits 31:16, off[1]=1 selects bits 15:0; off[0] is ignored.
  - Word: full data; offset is ignored.
  - Extend to 32 bits per load_unsigned.
- Result mux priority: link, then mem_to_reg (extracted load), then ALU result.
- rf_write = valid & reg_write & (dest≠0) & ~wb_stall. Writes to $zero are never issued.
- rf_addr = registered dest. rf_data = result mux output. Both are driven whenever valid; otherwise they are 0.
- Bypass for each port n:
  - byp_data_n = 0 if rd_addr_n = 0.
  - Otherwise rf_data if rf_write and rd_addr_n = rf_addr.
  - Otherwise rf_rdata_n.
- retire_count increments by 1 on each edge where valid & ~wb_stall, independent of reg_write. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rst_n low, asynchronous): valid=0, all stored fields 0, retire_count=0. Consequently rf_write=0, rf_addr=0, rf_data=0, and byp_data_n follows the bypass rule above.
- Latency: an instruction present on mem_* at edge N occupies WB during cycle N→N+1. Its register-file write commits at edge N+1 if it is not stalled.
- Bypass is purely combinational from the WB register and rd_addr/rf_rdata; zero added latency.
- Stalled instruction: no write and no count while the stall is high. It writes and counts exactly once, on the first unstalled edge.
- Reset asserted mid-stall or mid-write: state clears immediately. No write occurs at the following edge.
- Back-to-back writes to the same register: each commits in order, and the bypass always reflects the instruction currently in WB.

## Test plan
- Reset: hold rst_n=0 with mem_valid=1 → rf_write=0, rf_addr=0, rf_data=0, retire_count=0. First edge after release captures normally.
- ALU writeback: dest=5, alu_result=0x12345678, reg_write=1 → next cycle rf_write=1, rf_addr=5, rf_data=0x12345678. rd_addr1=5 with rf_rdata1=0xDEAD → byp_data1=0x12345678.
- Loads from load_data=0x80FF7F01:
  - LB offset 0 → 0xFFFFFF80.
  - LBU offset 0 → 0x00000080.
  - LB offset 2 → 0x0000007F.
  - LH offset 2 → 0x00007F01.
  - LH offset 0 → 0xFFFF80FF.
  - LW → 0x80FF7F01.
- Link and $zero:
  - mem_link=1, link_addr=0x00400010, mem_to_reg=1 → rf_data=0x00400010.
  - dest=0, reg_write=1 → rf_write=0, retire_count increments, byp_data for rd_addr=0 is 0.
- Stall/flush:
  - Stall 3 cycles with a valid instruction in WB → rf_write=0 for those 3 cycles, then one write and retire_count+1.
  - wb_flush=1 during the stall → valid clears, no write, count unchanged.
- Wrap: preload 0xFFFFFFFF retirements (or force the counter) then retire one → retire_count=0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// MEM/WB interface bundle: retiring instruction from MEM, ID read ports,
// register-file write port, bypass outputs and the retire counter.
interface writeback_stage_if;
  logic        wb_stall;
  logic        wb_flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic        mem_link;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic [1:0]  mem_byte_off;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_link_addr;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic [31:0] retire_count;

  modport slave (
    input  wb_stall, wb_flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_link,
           mem_load_size, mem_load_unsigned, mem_byte_off, mem_dest,
           mem_alu_result, mem_load_data, mem_link_addr,
           rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
    output rf_write, rf_addr, rf_data, byp_data1, byp_data2, retire_count
  );

  modport master (
    output wb_stall, wb_flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_link,
           mem_load_size, mem_load_unsigned, mem_byte_off, mem_dest,
           mem_alu_result, mem_load_data, mem_link_addr,
           rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
    input  rf_write, rf_addr, rf_data, byp_data1, byp_data2, retire_count
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write driver: result selection,
// big-endian load extraction, write-through bypass to ID, retire counter.
module writeback_stage (
  input  logic               clk,
  input  logic               rst_n,
  writeback_stage_if.slave   wb
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        link;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  byte_off;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] link_addr;
  } wb_fields_t;

  wb_fields_t  mem_fields;
  wb_fields_t  fields_d, fields_q;
  logic        valid_d, valid_q;
  logic [31:0] retire_count_d, retire_count_q;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] result;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  always_comb begin
    mem_fields.reg_write     = wb.mem_reg_write;
    mem_fields.mem_to_reg    = wb.mem_mem_to_reg;
    mem_fields.link          = wb.mem_link;
    mem_fields.load_size     = wb.mem_load_size;
    mem_fields.load_unsigned = wb.mem_load_unsigned;
    mem_fields.byte_off      = wb.mem_byte_off;
    mem_fields.dest          = wb.mem_dest;
    mem_fields.alu_result    = wb.mem_alu_result;
    mem_fields.load_data     = wb.mem_load_data;
    mem_fields.link_addr     = wb.mem_link_addr;
  end

  // Flush kills the valid bit even while stalled; the fields simply hold.
  // NOTE: every combinational output gets its default first so no latch is inferred.
  always_comb begin
    fields_d       = fields_q;
    valid_d        = valid_q & ~wb.wb_flush;
    retire_count_d = retire_count_q;
    if (!wb.wb_stall) begin
      fields_d = mem_fields;
      valid_d  = wb.mem_valid & ~wb.wb_flush;
    end
    if (valid_q && !wb.wb_stall) begin
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  // NOTE: state uses non-blocking assignments; all stored fields reset so the
  // write port reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q       <= '0;
      valid_q        <= 1'b0;
      retire_count_q <= '0;
    end else begin
      fields_q       <= fields_d;
      valid_q        <= valid_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    load_byte = 8'h00;
    case (fields_q.byte_off)
      2'd0:    load_byte = fields_q.load_data[31:24];
      2'd1:    load_byte = fields_q.load_data[23:16];
      2'd2:    load_byte = fields_q.load_data[15:8];
      default: load_byte = fields_q.load_data[7:0];
    endcase
    load_half = fields_q.byte_off[1] ? fields_q.load_data[15:0] : fields_q.load_data[31:16];
    case (fields_q.load_size)
      2'b01:   load_ext = {{16{~fields_q.load_unsigned & load_half[15]}}, load_half};
      2'b10:   load_ext = {{24{~fields_q.load_unsigned & load_byte[7]}}, load_byte};
      default: load_ext = fields_q.load_data;
    endcase
  end

  always_comb begin
    if (fields_q.link) begin
      result = fields_q.link_addr;
    end else if (fields_q.mem_to_reg) begin
      result = load_ext;
    end else begin
      result = fields_q.alu_result;
    end
  end

  assign rf_write = valid_q & fields_q.reg_write & (|fields_q.dest) & ~wb.wb_stall;
  assign rf_addr  = valid_q ? fields_q.dest : 5'd0;
  assign rf_data  = valid_q ? result : 32'd0;

  assign wb.rf_write     = rf_write;
  assign wb.rf_addr      = rf_addr;
  assign wb.rf_data      = rf_data;
  assign wb.retire_count = retire_count_q;

  // Write-through: ID sees the value being written this cycle; $zero reads 0.
  assign wb.byp_data1 = (wb.rd_addr1 == 5'd0) ? 32'd0 :
                        (rf_write && wb.rd_addr1 == rf_addr) ? rf_data : wb.rf_rdata1;
  assign wb.byp_data2 = (wb.rd_addr2 == 5'd0) ? 32'd0 :
                        (rf_write && wb.rd_addr2 == rf_addr) ? rf_data : wb.rf_rdata2;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the WB stage.
module tb_writeback_stage;

  logic clk;
  logic rst_n;
  writeback_stage_if wif ();

  writeback_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        link;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] lnk;
  } instr_t;

  instr_t      m_wb;
  logic [31:0] m_count;
  int          errors = 0;
  int          checks = 0;

  // Reference result from the ISA rules: shift the addressed lane down, mask, extend.
  function automatic logic [31:0] ref_result(input instr_t i);
    logic [31:0] v;
    if (i.link) return i.lnk;
    if (!i.mem_to_reg) return i.alu;
    case (i.size)
      2'b10: begin
        v = (i.ld >> (8 * (3 - i.off))) & 32'h0000_00FF;
        if (!i.uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (i.ld >> (i.off[1] ? 0 : 16)) & 32'h0000_FFFF;
        if (!i.uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = i.ld;
    endcase
    return v;
  endfunction

  function automatic instr_t mk_alu(input logic [4:0] dest, input logic [31:0] alu);
    instr_t i = '0;
    i.valid = 1'b1; i.reg_write = 1'b1; i.dest = dest; i.alu = alu;
    i.ld = 32'hA5A5_A5A5; i.lnk = 32'h5A5A_5A5A;
    return i;
  endfunction

  function automatic instr_t mk_load(input logic [1:0] size, input logic uns,
                                     input logic [1:0] off, input logic [31:0] ld);
    instr_t i = '0;
    i.valid = 1'b1; i.reg_write = 1'b1; i.mem_to_reg = 1'b1; i.dest = 5'd12;
    i.size = size; i.uns = uns; i.off = off; i.ld = ld;
    i.alu = 32'hCAFE_0000; i.lnk = 32'h0BAD_0000;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    wif.mem_valid         = i.valid;
    wif.mem_reg_write     = i.reg_write;
    wif.mem_mem_to_reg    = i.mem_to_reg;
    wif.mem_link          = i.link;
    wif.mem_load_size     = i.size;
    wif.mem_load_unsigned = i.uns;
    wif.mem_byte_off      = i.off;
    wif.mem_dest          = i.dest;
    wif.mem_alu_result    = i.alu;
    wif.mem_load_data     = i.ld;
    wif.mem_link_addr     = i.lnk;
  endtask

  function automatic instr_t sample_mem();
    instr_t i;
    i.valid = wif.mem_valid; i.reg_write = wif.mem_reg_write;
    i.mem_to_reg = wif.mem_mem_to_reg; i.link = wif.mem_link;
    i.size = wif.mem_load_size; i.uns = wif.mem_load_unsigned;
    i.off = wif.mem_byte_off; i.dest = wif.mem_dest;
    i.alu = wif.mem_alu_result; i.ld = wif.mem_load_data; i.lnk = wif.mem_link_addr;
    return i;
  endfunction

  task automatic model_edge();
    if (m_wb.valid && !wif.wb_stall) m_count = m_count + 32'd1;
    if (wif.wb_stall) begin
      if (wif.wb_flush) m_wb.valid = 1'b0;
    end else begin
      m_wb = sample_mem();
      m_wb.valid = wif.mem_valid && !wif.wb_flush;
    end
  endtask

  // Inputs change at the falling edge; the model follows the rising edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    drive('0);
    wif.wb_stall = 1'b0;
    wif.wb_flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    wif.rd_addr1 = 5'd3; wif.rf_rdata1 = 32'h0000_AAAA;
    wif.rd_addr2 = 5'd0; wif.rf_rdata2 = 32'h1111_1111;
    rst_n = 1'b0;
    m_wb = '0; m_count = '0;
    drive(mk_alu(5'd3, 32'h3333_0003));
    tick(); tick();
    #1;
    checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", wif.rf_write); end
    checks++; if (wif.rf_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", wif.rf_addr); end
    checks++; if (wif.rf_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", wif.rf_data); end
    checks++; if (wif.retire_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", wif.retire_count); end
    checks++; if (wif.byp_data1 !== 32'h0000_AAAA) begin errors++; $display("FAIL reset_byp1: got %h expected 0000aaaa", wif.byp_data1); end
    checks++; if (wif.byp_data2 !== 32'd0) begin errors++; $display("FAIL reset_byp2: got %h expected 0", wif.byp_data2); end
    rst_n = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (wif.rf_write !== 1'b1) begin errors++; $display("FAIL post_reset_write: got %b expected 1", wif.rf_write); end
    checks++; if (wif.rf_addr !== 5'd3) begin errors++; $display("FAIL post_reset_addr: got %0d expected 3", wif.rf_addr); end
    checks++; if (wif.rf_data !== 32'h3333_0003) begin errors++; $display("FAIL post_reset_data: got %h expected 33330003", wif.rf_data); end
    checks++; if (wif.retire_count !== 32'd0) begin errors++; $display("FAIL post_reset_count: got %h expected 0", wif.retire_count); end
    tick();
  endtask

  task automatic test_alu();
    drive(mk_alu(5'd5, 32'h1234_5678));
    tick();
    idle();
    wif.rd_addr1 = 5'd5; wif.rf_rdata1 = 32'h0000_DEAD;
    wif.rd_addr2 = 5'd6; wif.rf_rdata2 = 32'h0000_BEEF;
    #1;
    checks++; if (wif.rf_write !== 1'b1) begin errors++; $display("FAIL alu_write: got %b expected 1", wif.rf_write); end
    checks++; if (wif.rf_addr !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d expected 5", wif.rf_addr); end
    checks++; if (wif.rf_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_data: got %h expected 12345678", wif.rf_data); end
    checks++; if (wif.byp_data1 !== 32'h1234_5678) begin errors++; $display("FAIL alu_byp1: got %h expected 12345678", wif.byp_data1); end
    checks++; if (wif.byp_data2 !== 32'h0000_BEEF) begin errors++; $display("FAIL alu_byp2: got %h expected 0000beef", wif.byp_data2); end
    tick();
    checks++; if (wif.retire_count !== m_count) begin errors++; $display("FAIL alu_count: got %h expected %h", wif.retire_count, m_count); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [12] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
    logic        un  [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  of  [12] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0,
                              2'd3, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
    logic [31:0] exp [12] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                              32'h0000_7F01, 32'hFFFF_80FF, 32'h80FF_7F01,
                              32'h0000_0001, 32'h0000_00FF, 32'hFFFF_FFFF,
                              32'h0000_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    // Back-to-back loads to the same register: each must appear in turn.
    for (int k = 0; k < 12; k++) begin
      drive(mk_load(sz[k], un[k], of[k], 32'h80FF_7F01));
      tick();
      #1;
      checks++;
      if (wif.rf_data !== exp[k]) begin
        errors++;
        $display("FAIL load_%0d (size %b uns %b off %0d): got %h expected %h",
                 k, sz[k], un[k], of[k], wif.rf_data, exp[k]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_link_zero();
    instr_t i;
    i = mk_load(2'b00, 1'b0, 2'd0, 32'h1111_2222);
    i.link = 1'b1; i.lnk = 32'h0040_0010; i.dest = 5'd31;
    drive(i);
    tick();
    #1;
    checks++; if (wif.rf_data !== 32'h0040_0010) begin errors++; $display("FAIL link_data: got %h expected 00400010", wif.rf_data); end
    checks++; if (wif.rf_addr !== 5'd31) begin errors++; $display("FAIL link_addr: got %0d expected 31", wif.rf_addr); end
    drive(mk_alu(5'd0, 32'h7777_7777));
    tick();
    idle();
    wif.rd_addr1 = 5'd0; wif.rf_rdata1 = 32'h0000_1234;
    #1;
    checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL zero_write: got %b expected 0", wif.rf_write); end
    checks++; if (wif.byp_data1 !== 32'd0) begin errors++; $display("FAIL zero_byp: got %h expected 0", wif.byp_data1); end
    tick();
    checks++; if (wif.retire_count !== m_count) begin errors++; $display("FAIL zero_count: got %h expected %h", wif.retire_count, m_count); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] c0;
    drive(mk_alu(5'd7, 32'h0000_0077));
    tick();
    c0 = m_count;
    wif.wb_stall = 1'b1;
    drive(mk_alu(5'd8, 32'h0000_0088));
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL stall_write_%0d: got %b expected 0", k, wif.rf_write); end
      checks++; if (wif.rf_addr !== 5'd7) begin errors++; $display("FAIL stall_addr_%0d: got %0d expected 7", k, wif.rf_addr); end
      tick();
    end
    checks++; if (wif.retire_count !== c0) begin errors++; $display("FAIL stall_count_held: got %h expected %h", wif.retire_count, c0); end
    idle();
    #1;
    checks++; if (wif.rf_write !== 1'b1) begin errors++; $display("FAIL unstall_write: got %b expected 1", wif.rf_write); end
    checks++; if (wif.rf_data !== 32'h0000_0077) begin errors++; $display("FAIL unstall_data: got %h expected 00000077", wif.rf_data); end
    tick();
    checks++; if (wif.retire_count !== c0 + 32'd1) begin errors++; $display("FAIL unstall_count: got %h expected %h", wif.retire_count, c0 + 32'd1); end
    checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL after_unstall_write: got %b expected 0", wif.rf_write); end

    drive(mk_alu(5'd9, 32'h0000_0099));
    tick();
    c0 = m_count;
    wif.wb_stall = 1'b1;
    tick();
    wif.wb_flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL flush_write: got %b expected 0", wif.rf_write); end
    checks++; if (wif.rf_addr !== 5'd0) begin errors++; $display("FAIL flush_addr: got %0d expected 0", wif.rf_addr); end
    tick();
    checks++; if (wif.retire_count !== c0) begin errors++; $display("FAIL flush_count: got %h expected %h", wif.retire_count, c0); end

    drive(mk_alu(5'd4, 32'h0000_0044));
    wif.wb_flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL flush_capture_write: got %b expected 0", wif.rf_write); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(mk_alu(5'd10, 32'h0000_00AA));
    tick();
    wif.wb_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    m_wb = '0; m_count = '0;
    #1;
    checks++; if (wif.rf_addr !== 5'd0) begin errors++; $display("FAIL midreset_addr: got %0d expected 0", wif.rf_addr); end
    checks++; if (wif.retire_count !== 32'd0) begin errors++; $display("FAIL midreset_count: got %h expected 0", wif.retire_count); end
    idle();
    rst_n = 1'b1;
    #1;
    checks++; if (wif.rf_write !== 1'b0) begin errors++; $display("FAIL midreset_write: got %b expected 0", wif.rf_write); end
    tick();
    checks++; if (wif.retire_count !== 32'd0) begin errors++; $display("FAIL midreset_count_after: got %h expected 0", wif.retire_count); end
  endtask

  task automatic test_random();
    instr_t      i;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_b1, exp_b2;
    for (int n = 0; n < 400; n++) begin
      i.valid      = ($urandom_range(0, 9) < 8);
      i.reg_write  = ($urandom_range(0, 9) < 8);
      i.mem_to_reg = $urandom_range(0, 1);
      i.link       = ($urandom_range(0, 7) == 0);
      i.size       = 2'($urandom_range(0, 3));
      i.uns        = $urandom_range(0, 1);
      i.off        = 2'($urandom_range(0, 3));
      i.dest       = 5'($urandom_range(0, 7));
      i.alu        = $urandom;
      i.ld         = $urandom;
      i.lnk        = $urandom;
      drive(i);
      wif.wb_stall  = ($urandom_range(0, 4) == 0);
      wif.wb_flush  = ($urandom_range(0, 9) == 0);
      wif.rd_addr1  = 5'($urandom_range(0, 7));
      wif.rd_addr2  = 5'($urandom_range(0, 7));
      wif.rf_rdata1 = $urandom;
      wif.rf_rdata2 = $urandom;
      #1;
      exp_we   = m_wb.valid && m_wb.reg_write && (m_wb.dest != 5'd0) && !wif.wb_stall;
      exp_addr = m_wb.valid ? m_wb.dest : 5'd0;
      exp_data = m_wb.valid ? ref_result(m_wb) : 32'd0;
      exp_b1   = (wif.rd_addr1 == 5'd0) ? 32'd0 :
                 (exp_we && wif.rd_addr1 == exp_addr) ? exp_data : wif.rf_rdata1;
      exp_b2   = (wif.rd_addr2 == 5'd0) ? 32'd0 :
                 (exp_we && wif.rd_addr2 == exp_addr) ? exp_data : wif.rf_rdata2;
      checks++; if (wif.rf_write !== exp_we) begin errors++; $display("FAIL rand_write[%0d]: got %b expected %b", n, wif.rf_write, exp_we); end
      checks++; if (wif.rf_addr !== exp_addr) begin errors++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", n, wif.rf_addr, exp_addr); end
      checks++; if (wif.rf_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, wif.rf_data, exp_data); end
      checks++; if (wif.byp_data1 !== exp_b1) begin errors++; $display("FAIL rand_byp1[%0d]: got %h expected %h", n, wif.byp_data1, exp_b1); end
      checks++; if (wif.byp_data2 !== exp_b2) begin errors++; $display("FAIL rand_byp2[%0d]: got %h expected %h", n, wif.byp_data2, exp_b2); end
      checks++; if (wif.retire_count !== m_count) begin errors++; $display("FAIL rand_count[%0d]: got %h expected %h", n, wif.retire_count, m_count); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_wrap();
    idle();
    tick();
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    m_count = 32'hFFFF_FFFF;
    drive(mk_alu(5'd2, 32'h0000_0002));
    tick();
    idle();
    #1;
    checks++; if (wif.retire_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", wif.retire_count); end
    tick();
    checks++; if (wif.retire_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h expected 0", wif.retire_count); end
    checks++; if (wif.retire_count !== m_count) begin errors++; $display("FAIL wrap_model: got %h expected %h", wif.retire_count, m_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wif.rd_addr1 = '0; wif.rd_addr2 = '0;
    wif.rf_rdata1 = '0; wif.rf_rdata2 = '0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_loads();
    test_link_zero();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
